vpd_capability_ctrl: RTL and testbench

//   PCIe VPD capability engine: VPD Address register (F flag + dword-aligned address) and VPD Data register,

---
 rtl/vpd_capability_ctrl.sv | 126 ++++++++++++
 tb/tb_vpd_capability_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/vpd_capability_ctrl.sv
// vpd_capability_ctrl: PCIe VPD Address/Data registers and the one-dword storage transfer FSM.
// Optional macro VPD_TIMEOUT_EN aborts a stalled storage request after TIMEOUT_CYCLES.
module vpd_capability_ctrl #(
    parameter int ADDR_WIDTH     = 15,
    parameter int DATA_WIDTH     = 32,
    parameter int RO_DWORDS      = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  addr_wr,
    input  logic [15:0]           addr_wdata,
    input  logic                  data_wr,
    input  logic [DATA_WIDTH-1:0] data_wdata,
    output logic [15:0]           addr_rdata,
    output logic [DATA_WIDTH-1:0] data_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  err_ro,
    output logic                  err_timeout
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

    state_t                state_q, state_d;
    logic                  f_q, f_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  err_ro_q, err_ro_d;
    logic                  err_to_q, err_to_d;
    logic                  expired;
    logic                  aligned;
    logic                  ro_hit;

`ifdef VPD_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;

    // Counter restarts from zero on every newly accepted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= (state_q == IDLE) ? '0 : cnt_q + 1'b1;
    end

    assign expired = (state_q != IDLE) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign expired        = 1'b0;
`endif

    assign aligned = addr_wdata[1:0] == 2'b00;
    assign ro_hit  = 32'(addr_wdata[ADDR_WIDTH-1:2]) < RO_DWORDS;

    always_comb begin
        state_d  = state_q;
        f_d      = f_q;
        addr_d   = addr_q;
        data_d   = data_q;
        err_ro_d = 1'b0;
        err_to_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_wr) data_d = data_wdata;
                if (addr_wr && aligned) begin
                    addr_d   = addr_wdata[ADDR_WIDTH-1:0];
                    f_d      = addr_wdata[15] && !ro_hit;
                    err_ro_d = addr_wdata[15] && ro_hit;
                    state_d  = !addr_wdata[15] ? RD_WAIT : ro_hit ? IDLE : WR_WAIT;
                end
            end
            RD_WAIT: begin
                if (mem_ack) begin
                    data_d  = mem_rdata;
                    f_d     = 1'b1;
                    state_d = IDLE;
                end else if (expired) begin
                    err_to_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            WR_WAIT: begin
                if (mem_ack) begin
                    f_d     = 1'b0;
                    state_d = IDLE;
                end else if (expired) begin
                    err_to_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            f_q      <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            err_ro_q <= 1'b0;
            err_to_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            f_q      <= f_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            err_ro_q <= err_ro_d;
            err_to_q <= err_to_d;
        end
    end

    assign addr_rdata  = {f_q, 15'(addr_q)};
    assign data_rdata  = data_q;
    assign mem_req     = state_q != IDLE;
    assign busy        = state_q != IDLE;
    assign mem_we      = state_q == WR_WAIT;
    assign mem_addr    = addr_q[ADDR_WIDTH-1:2];
    assign mem_wdata   = data_q;
    assign err_ro      = err_ro_q;
    assign err_timeout = err_to_q;
endmodule

// File: tb/tb_vpd_capability_ctrl.sv
// tb_vpd_capability_ctrl: directed self-checking bench for the VPD capability engine.
module tb_vpd_capability_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        addr_wr = 1'b0;
    logic [15:0] addr_wdata = '0;
    logic        data_wr = 1'b0;
    logic [31:0] data_wdata = '0;
    logic [15:0] addr_rdata;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        busy;
    logic        err_ro;
    logic        err_timeout;
    int          checks = 0;
    int          errors = 0;

    vpd_capability_ctrl #(
        .ADDR_WIDTH(15), .DATA_WIDTH(32), .RO_DWORDS(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .addr_wr(addr_wr), .addr_wdata(addr_wdata),
        .data_wr(data_wr), .data_wdata(data_wdata),
        .addr_rdata(addr_rdata), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .err_ro(err_ro), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        addr_wr = 1'b0;
        data_wr = 1'b0;
        mem_ack = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_addr", 32'(addr_rdata), 0);
        chk("rst_data", data_rdata, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_errs", {30'd0, err_ro, err_timeout}, 0);
        step();
        step();
        rst = 1'b0;
        step();

        addr_wr = 1'b1; addr_wdata = 16'h0010;
        step();
        chk("rd_req", 32'(mem_req), 1);
        chk("rd_we", 32'(mem_we), 0);
        chk("rd_maddr", 32'(mem_addr), 4);
        chk("rd_busy", 32'(busy), 1);
        chk("rd_addr_f0", 32'(addr_rdata), 32'h0010);

        addr_wr = 1'b1; addr_wdata = 16'h8040;
        data_wr = 1'b1; data_wdata = 32'hFFFF_FFFF;
        step();
        chk("busy_addr_ign", 32'(addr_rdata), 32'h0010);
        chk("busy_data_ign", data_rdata, 0);
        chk("busy_req", 32'(mem_req), 1);

        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        addr_wr = 1'b1; addr_wdata = 16'h0040;
        step();
        chk("rd_data", data_rdata, 32'hDEAD_BEEF);
        chk("rd_done_addr", 32'(addr_rdata), 32'h8010);
        chk("rd_done_req", 32'(mem_req), 0);
        chk("rd_done_busy", 32'(busy), 0);

        mem_ack = 1'b1; mem_rdata = 32'h0000_0001;
        step();
        chk("idle_ack_data", data_rdata, 32'hDEAD_BEEF);
        chk("idle_ack_addr", 32'(addr_rdata), 32'h8010);

        addr_wr = 1'b1; addr_wdata = 16'h0013;
        step();
        chk("misalign_addr", 32'(addr_rdata), 32'h8010);
        chk("misalign_req", 32'(mem_req), 0);

        data_wr = 1'b1; data_wdata = 32'h1234_5678;
        step();
        chk("dwr_data", data_rdata, 32'h1234_5678);
        chk("dwr_f_keep", 32'(addr_rdata), 32'h8010);

        addr_wr = 1'b1; addr_wdata = 16'h8020;
        step();
        chk("wr_req", 32'(mem_req), 1);
        chk("wr_we", 32'(mem_we), 1);
        chk("wr_maddr", 32'(mem_addr), 8);
        chk("wr_wdata", mem_wdata, 32'h1234_5678);
        chk("wr_addr_f1", 32'(addr_rdata), 32'h8020);
        step();
        step();
        chk("wr_hold", 32'(mem_req), 1);
        mem_ack = 1'b1;
        step();
        chk("wr_done_addr", 32'(addr_rdata), 32'h0020);
        chk("wr_done_busy", 32'(busy), 0);
        chk("wr_done_req", 32'(mem_req), 0);

        addr_wr = 1'b1; addr_wdata = 16'h8008;
        step();
        chk("ro_err", 32'(err_ro), 1);
        chk("ro_req", 32'(mem_req), 0);
        chk("ro_addr", 32'(addr_rdata), 32'h0008);
        step();
        chk("ro_err_pulse", 32'(err_ro), 0);

        addr_wr = 1'b1; addr_wdata = 16'h800C;
        step();
        chk("ro_last_err", 32'(err_ro), 1);
        chk("ro_last_req", 32'(mem_req), 0);
        addr_wr = 1'b1; addr_wdata = 16'h8010;
        step();
        chk("ro_first_ok_err", 32'(err_ro), 0);
        chk("ro_first_ok_req", 32'(mem_req), 1);
        chk("ro_first_ok_addr", 32'(addr_rdata), 32'h8010);
        mem_ack = 1'b1;
        step();

        addr_wr = 1'b1; addr_wdata = 16'h0004;
        step();
        chk("rd_ro_req", 32'(mem_req), 1);
        mem_ack = 1'b1; mem_rdata = 32'h0000_A5A5;
        step();
        addr_wr = 1'b1; addr_wdata = 16'h0008;
        step();
        chk("b2b_data", data_rdata, 32'h0000_A5A5);
        chk("b2b_req", 32'(mem_req), 1);
        chk("b2b_maddr", 32'(mem_addr), 2);

`ifdef VPD_TIMEOUT_EN
        for (int i = 1; i < 8; i++) begin
            chk("to_hold", 32'(mem_req), 1);
            step();
        end
        chk("to_hold_last", 32'(mem_req), 1);
        step();
        chk("to_req", 32'(mem_req), 0);
        chk("to_err", 32'(err_timeout), 1);
        chk("to_f0", 32'(addr_rdata), 32'h0008);
        step();
        chk("to_err_pulse", 32'(err_timeout), 0);
`else
        for (int i = 0; i < 20; i++) step();
        chk("noto_hold", 32'(mem_req), 1);
        chk("noto_err", 32'(err_timeout), 0);
        mem_ack = 1'b1; mem_rdata = 32'h0;
        step();
        chk("noto_done", 32'(addr_rdata), 32'h8008);
`endif

        data_wr = 1'b1; data_wdata = 32'h0000_0055;
        step();
        addr_wr = 1'b1; addr_wdata = 16'h8040;
        step();
        chk("rstw_req", 32'(mem_req), 1);
        chk("rstw_we", 32'(mem_we), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstw_req0", 32'(mem_req), 0);
        chk("rstw_addr0", 32'(addr_rdata), 0);
        chk("rstw_data0", data_rdata, 0);
        chk("rstw_busy0", 32'(busy), 0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_req", 32'(mem_req), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
